// File: rtl/pipeline_sched_pkg.sv
// Shared width helpers for the round-robin pipeline scheduler.
package pipeline_sched_pkg;

    // Requester index width; at least one bit even for a single requester.
    function automatic int id_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Width of a counter that must hold 0..d inclusive.
    function automatic int cnt_w(input int d);
        return $clog2(d + 1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after last+1, with wrap.
module rr_arbiter
    import pipeline_sched_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int ID_W = id_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic            en,
    input  logic [ID_W-1:0] last,
    output logic [NREQ-1:0] gnt,
    output logic [ID_W-1:0] idx
);

    // Walk the search order backwards so the nearest candidate after 'last' is
    // the final assignment and wins; no separate "found" flag is needed.
    always_comb begin
        gnt = '0;
        idx = '0;
        for (int k = NREQ; k >= 1; k--) begin
            int j;
            j = int'(last) + k;
            if (j >= NREQ) j = j - NREQ;
            if (en && req[j]) begin
                gnt = NREQ'(1) << j;
                idx = ID_W'(j);
            end
        end
    end

endmodule

// File: rtl/pipeline_rr_scheduler.sv
// Round-robin issue into a shared DEPTH-stage pipeline with valid/ready output.
// The whole pipeline advances together; output backpressure freezes every stage.
module pipeline_rr_scheduler
    import pipeline_sched_pkg::*;
#(
    parameter  int SIZE  = 8,
    parameter  int NREQ  = 4,
    parameter  int DEPTH = 2,
    localparam int ID_W  = id_w(NREQ),
    localparam int CNT_W = cnt_w(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*SIZE-1:0] req_data,
    input  logic                 pause,
    output logic [NREQ-1:0]      gnt,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SIZE-1:0]      out_data,
    output logic [ID_W-1:0]      out_id,
    output logic                 busy,
    output logic [CNT_W-1:0]     inflight
);

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
        logic [SIZE-1:0] data;
    } stage_t;

    stage_t [DEPTH-1:0] stage_q, stage_d;
    logic   [ID_W-1:0]  last_q, last_d;

    logic            advance;
    logic            issue_en;
    logic [ID_W-1:0] gnt_idx;
    logic [SIZE-1:0] sel_data;

    assign out_valid = stage_q[DEPTH-1].valid;
    assign out_data  = stage_q[DEPTH-1].data;
    assign out_id    = stage_q[DEPTH-1].id;
    assign advance   = !out_valid || out_ready;
    // No grant while reset is held so nothing is accepted and then discarded.
    assign issue_en  = advance && !pause && !rst;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req  (req),
        .en   (issue_en),
        .last (last_q),
        .gnt  (gnt),
        .idx  (gnt_idx)
    );

    // Mux the granted requester's word; gnt is one-hot or zero.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) sel_data = req_data[i*SIZE +: SIZE];
        end
    end

    // Next stage contents and pointer: shift on advance, stage 0 takes grant or bubble.
    always_comb begin
        stage_d = stage_q;
        last_d  = last_q;
        if (advance) begin
            for (int k = 1; k < DEPTH; k++) begin
                stage_d[k] = stage_q[k-1];
            end
            stage_d[0] = '0;
            if (|gnt) begin
                stage_d[0].valid = 1'b1;
                stage_d[0].id    = gnt_idx;
                stage_d[0].data  = sel_data;
                last_d           = gnt_idx;
            end
        end
    end

    // Stage array and pointer registers; pointer resets so requester 0 goes first.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= '0;
            last_q  <= ID_W'(NREQ - 1);
        end else begin
            stage_q <= stage_d;
            last_q  <= last_d;
        end
    end

    // Occupancy: popcount of stage valid bits.
    always_comb begin
        inflight = '0;
        for (int k = 0; k < DEPTH; k++) begin
            inflight = inflight + CNT_W'(stage_q[k].valid);
        end
        busy = (inflight != '0);
    end

endmodule

// File: tb/tb_pipeline_rr_scheduler.sv
// Randomized and directed bench for pipeline_rr_scheduler against a slot-queue model.
module tb_pipeline_rr_scheduler;

    localparam int SIZE  = 8;
    localparam int NREQ  = 4;
    localparam int DEPTH = 2;
    localparam int ID_W  = 2;
    localparam int CNT_W = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req;
    logic [NREQ*SIZE-1:0] req_data;
    logic                 pause;
    logic [NREQ-1:0]      gnt;
    logic                 out_valid;
    logic                 out_ready;
    logic [SIZE-1:0]      out_data;
    logic [ID_W-1:0]      out_id;
    logic                 busy;
    logic [CNT_W-1:0]     inflight;

    pipeline_rr_scheduler #(.SIZE(SIZE), .NREQ(NREQ), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_data  (req_data),
        .pause     (pause),
        .gnt       (gnt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id),
        .busy      (busy),
        .inflight  (inflight)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model: slot 0 is the issue slot, slot DEPTH-1 is the output slot.
    int m_v    [DEPTH];
    int m_id   [DEPTH];
    int m_data [DEPTH];
    int m_last;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < DEPTH; k++) begin
            m_v[k] = 0; m_id[k] = 0; m_data[k] = 0;
        end
        m_last = NREQ - 1;
    endtask

    // One cycle: check outputs mid-cycle, then advance the model on the edge.
    task automatic step();
        int win, n, p;
        logic ov, adv;
        logic [NREQ-1:0] eg;
        @(negedge clk);
        ov  = (m_v[DEPTH-1] != 0);
        adv = !ov || out_ready;
        win = -1;
        if (!rst && adv && !pause) begin
            for (int k = 1; k <= NREQ; k++) begin
                p = (m_last + k) % NREQ;
                if (win < 0 && req[p]) win = p;
            end
        end
        eg = '0;
        if (win >= 0) eg[win] = 1'b1;
        n = 0;
        for (int k = 0; k < DEPTH; k++) n += m_v[k];
        chk("gnt", 32'(gnt), 32'(eg));
        chk("out_valid", 32'(out_valid), 32'(ov));
        if (ov) begin
            chk("out_data", 32'(out_data), 32'(m_data[DEPTH-1]));
            chk("out_id", 32'(out_id), 32'(m_id[DEPTH-1]));
        end
        chk("busy", 32'(busy), 32'(n != 0));
        chk("inflight", 32'(inflight), 32'(n));
        @(posedge clk);
        if (rst) begin
            model_clear();
        end else if (adv) begin
            for (int k = DEPTH - 1; k >= 1; k--) begin
                m_v[k] = m_v[k-1]; m_id[k] = m_id[k-1]; m_data[k] = m_data[k-1];
            end
            m_v[0]    = (win >= 0) ? 1 : 0;
            m_id[0]   = (win >= 0) ? win : 0;
            m_data[0] = (win >= 0) ? int'(req_data[win*SIZE +: SIZE]) : 0;
            if (win >= 0) m_last = win;
        end
        #1;
    endtask

    task automatic set_data_pattern(input int base);
        for (int i = 0; i < NREQ; i++) req_data[i*SIZE +: SIZE] = 8'(base + 16 * i + i);
    endtask

    initial begin
        rst = 1'b1; req = '1; pause = 1'b0; out_ready = 1'b1;
        set_data_pattern(8'h11);
        @(posedge clk);
        #1;
        model_clear();

        // Reset held with all requests high: no grants, pipeline empty.
        repeat (3) step();
        chk("rst_out_data", 32'(out_data), 32'h0);
        chk("rst_out_id", 32'(out_id), 32'h0);

        // Release: first grant goes to requester 0.
        rst = 1'b0;
        step();

        // Single requester 2 with A5.
        req = 4'b0100;
        req_data[2*SIZE +: SIZE] = 8'hA5;
        repeat (6) step();

        // Fairness across all four, then alternate 1 and 3.
        req = 4'b1111;
        set_data_pattern(8'h20);
        repeat (8) step();
        req = 4'b1010;
        repeat (6) step();

        // Backpressure with a full pipeline.
        req = 4'b1111;
        set_data_pattern(8'h40);
        repeat (4) step();
        out_ready = 1'b0;
        repeat (3) step();
        out_ready = 1'b1;
        repeat (4) step();

        // Pause and drain, then resume.
        pause = 1'b1;
        repeat (4) step();
        pause = 1'b0;
        repeat (3) step();

        // Reset mid-stream while stalled with two words in flight.
        out_ready = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        out_ready = 1'b1;
        repeat (4) step();

        // Random traffic.
        for (int c = 0; c < 400; c++) begin
            req       = NREQ'($urandom);
            req_data  = {$urandom};
            pause     = ($urandom_range(0, 3) == 0);
            out_ready = ($urandom_range(0, 9) < 7);
            rst       = ($urandom_range(0, 49) == 0);
            step();
        end
        rst = 1'b0; pause = 1'b0; out_ready = 1'b1; req = '0;
        repeat (4) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
